// File: rtl/mult_seq_16b_pkg.sv
// Shared types and constants for the iterative 16x16 multiplier.
// State encoding, step count and counter width live here.
package mult_seq_16b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MULT_STEPS = 16;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mult_seq_16b_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with
// group generate/propagate feeding a second lookahead level.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  function automatic logic [3:0] grp_c(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       ci
  );
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0])
         | (&p[2:0] & ci);
    return c;
  endfunction

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [3:0]  w_cg;

  assign w_g = a & b;
  assign w_p = a ^ b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    logic [3:0] w_gj;
    logic [3:0] w_pj;
    assign w_gj = w_g[4*j +: 4];
    assign w_pj = w_p[4*j +: 4];
    assign w_gg[j] = w_gj[3] | (w_pj[3] & w_gj[2])
                   | (&w_pj[3:2] & w_gj[1])
                   | (&w_pj[3:1] & w_gj[0]);
    assign w_gp[j] = &w_pj;
    assign w_c[4*j +: 4] = grp_c(w_gj, w_pj, w_cg[j]);
  end

  // second lookahead level across the four groups
  assign w_cg[0] = c_in;
  assign w_cg[1] = w_gg[0] | (w_gp[0] & c_in);
  assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0])
                 | (&w_gp[1:0] & c_in);
  assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1])
                 | (&w_gp[2:1] & w_gg[0])
                 | (&w_gp[2:0] & c_in);
  assign c_out   = w_gg[3] | (w_gp[3] & w_cg[3]);

  assign sum = w_p ^ w_c;

endmodule

// File: rtl/mult_seq_16b_flop.sv
// Flop primitive: D register with synchronous active-low clear.
// Every multiplier register is built from this cell.
module flop_srn #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/mult_seq_16b.sv
// Iterative unsigned 16x16 shift-add multiplier, one step per cycle,
// sharing the execute-stage 16-bit CLA for each partial-product add.
module mult_seq_16b
  import mult_seq_16b_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           kill,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  logic [1:0]       r_state;
  logic [N-1:0]     r_m;
  logic [2*N:0]     r_p;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state;
  state_t           w_state_d;
  logic [N-1:0]     w_m_d;
  logic [2*N:0]     w_p_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [N-1:0]     w_sum;
  logic             w_cout;
  logic [N:0]       w_hi;

  flop_srn #(.W(2)) u_st (
    .clk(clk), .rst(rst), .d(w_state_d), .q(r_state)
  );
  flop_srn #(.W(N)) u_m (
    .clk(clk), .rst(rst), .d(w_m_d), .q(r_m)
  );
  flop_srn #(.W(2*N+1)) u_p (
    .clk(clk), .rst(rst), .d(w_p_d), .q(r_p)
  );
  flop_srn #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .d(w_cnt_d), .q(r_cnt)
  );

  cla_16b u_cla (
    .a    (r_p[2*N-1:N]),
    .b    (r_m),
    .c_in (1'b0),
    .sum  (w_sum),
    .c_out(w_cout)
  );

  assign w_state = state_t'(r_state);

  // P[32] is always zero entering a step, so the skip path
  // simply passes the 17-bit high part through
  assign w_hi = r_p[0] ? {w_cout, w_sum} : r_p[2*N:N];

  always_comb begin
    w_state_d = w_state;
    w_m_d     = r_m;
    w_p_d     = r_p;
    w_cnt_d   = r_cnt;
    if (kill) begin
      w_state_d = ST_IDLE;
      w_m_d     = '0;
      w_p_d     = '0;
      w_cnt_d   = '0;
    end else begin
      unique case (w_state)
        ST_IDLE: begin
          if (in_valid) begin
            w_state_d = ST_RUN;
            w_m_d     = a;
            w_p_d     = {{(N+1){1'b0}}, b};
            w_cnt_d   = '0;
          end
        end
        ST_RUN: begin
          w_p_d   = {1'b0, w_hi, r_p[N-1:1]};
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(MULT_STEPS - 1))
            w_state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) w_state_d = ST_IDLE;
        end
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (w_state == ST_IDLE);
  assign out_valid = (w_state == ST_DONE);
  assign product   = r_p[2*N-1:0];

endmodule

// File: tb/tb_mult_seq_16b.sv
// Directed plus random checks of mult_seq_16b against a*b
// computed with plain arithmetic, including latency and flush cases.
module tb_mult_seq_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int n_vec = 0;
  int n_err = 0;

  mult_seq_16b dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .kill     (kill),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(
    input logic [15:0] x,
    input logic [15:0] y
  );
    logic [31:0] xx;
    logic [31:0] yy;
    xx = {16'b0, x};
    yy = {16'b0, y};
    return xx * yy;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // entered at the falling edge right after the accept edge
  task automatic wait_result(
    input string       tag,
    input logic [31:0] exp
  );
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd16);
    chk({tag, "_prod"}, product, exp);
  endtask

  task automatic run_op(
    input string       tag,
    input logic [15:0] x,
    input logic [15:0] y,
    input int          hold
  );
    logic [31:0] exp;
    exp       = ref_mul(x, y);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    out_ready = (hold == 0);
    chk({tag, "_rdy0"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    wait_result(tag, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_p"}, product, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_v"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    logic [15:0] rx;
    logic [15:0] ry;
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    kill      = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_val", 32'(out_valid), 32'd0);
    chk("rst_prod", product, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("basic", 16'd3, 16'd5, 0);
    run_op("max", 16'hFFFF, 16'hFFFF, 0);
    run_op("zero", 16'h0000, 16'h1234, 0);
    run_op("ident", 16'h1234, 16'h0001, 0);
    run_op("msb", 16'h8000, 16'h8000, 0);

    // back-pressure with the next request already waiting
    in_valid  = 1'b1;
    a         = 16'h00FF;
    b         = 16'h0101;
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'd2;
    b = 16'd3;
    wait_result("bp", 32'h0000FFFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_v", 32'(out_valid), 32'd1);
      chk("bp_hold_p", product, 32'h0000FFFF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", 32'(in_ready), 32'd1);
    chk("bp_noval", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("bp_acc", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_result("bp2", 32'd6);
    @(negedge clk);
    chk("bp2_idle", 32'(in_ready), 32'd1);

    // synchronous reset during step 7
    in_valid = 1'b1;
    a        = 16'h4321;
    b        = 16'h00F7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    chk("mrst_val", 32'(out_valid), 32'd0);
    chk("mrst_prod", product, 32'd0);
    run_op("post_rst", 16'd7, 16'd9, 0);

    // flush during step 10: no result may ever appear
    in_valid = 1'b1;
    a        = 16'hABCD;
    b        = 16'h1357;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_rdy", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) pulses++;
    end
    chk("kill_nopulse", 32'(pulses), 32'd0);

    // flush while the result is waiting
    in_valid  = 1'b1;
    a         = 16'd100;
    b         = 16'd200;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("kdone", 32'd20000);
    kill = 1'b1;
    @(negedge clk);
    kill      = 1'b0;
    out_ready = 1'b1;
    chk("kdone_val", 32'(out_valid), 32'd0);
    chk("kdone_rdy", 32'(in_ready), 32'd1);

    // flush blocks a simultaneous request
    in_valid = 1'b1;
    kill     = 1'b1;
    a        = 16'd5;
    b        = 16'd5;
    @(negedge clk);
    in_valid = 1'b0;
    kill     = 1'b0;
    chk("kacc_rdy", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) pulses++;
    end
    chk("kacc_nopulse", 32'(pulses), 32'd0);

    for (int k = 0; k < 10; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_op("rand", rx, ry, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
